// File: rtl/des_pkg.sv
// DES key-schedule tables, shift schedules, FSM encoding and stage-order helpers.
// Pure declarations; no logic or state of its own.
package des_pkg;

  localparam int MAX_KEYS = 3;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Decrypt walks the encrypt sequence backwards, so its round 0 starts unrotated.
  localparam logic [1:0] SHIFT_E [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] SHIFT_D [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [1:0] stage_slot(input logic [1:0] stage, input logic dec, input int nk);
    if (nk == 1) return 2'd0;
    return dec ? (2'd2 - stage) : stage;
  endfunction

  // 1 = right-rotate (decrypt direction) for this stage.
  function automatic logic stage_dir(input logic [1:0] stage, input logic dec, input int nk);
    if (nk == 1) return dec;
    return dec ? (stage != 2'd1) : (stage == 2'd1);
  endfunction

  function automatic logic [1:0] shift_amt(input logic dir, input logic [3:0] r);
    return dir ? SHIFT_D[r] : SHIFT_E[r];
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n, input logic right);
    logic [27:0] y;
    y = x;
    case ({right, n})
      3'b001:  y = {x[26:0], x[27]};
      3'b010:  y = {x[25:0], x[27:26]};
      3'b101:  y = {x[0], x[27:1]};
      3'b110:  y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_subkey_pc2.sv
// PC-2 compression of the 56-bit C||D register into a 48-bit round subkey.
// Purely combinational, zero latency.
module des_subkey_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) subkey[47-i] = cd[56-PC2[i]];
  end

endmodule

// File: rtl/des_key_schedule_seq.sv
// Sequential DES/TDES key schedule: one PC-2 subkey per valid/ready handshake, first subkey 1 cycle after accept.
// Subkey and its tags hold while subkey_ready is low; new key jobs are refused until the current job drains.
module des_key_schedule_seq
  import des_pkg::*;
#(
  parameter int NUM_KEYS     = 1,
  parameter int PARITY_CHECK = 1,
  parameter int PARITY_BLOCK = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [64*NUM_KEYS-1:0]  key,
  input  logic                    decrypt,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output logic [47:0]             subkey,
  output logic [3:0]              subkey_round,
  output logic [1:0]              subkey_stage,
  output logic                    subkey_last,
  output logic                    parity_err,
  output logic                    busy
);

  generate
    if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
      $error("des_key_schedule_seq: NUM_KEYS must be 1 or 3");
    end
  endgenerate

  localparam logic [1:0] LAST_STAGE = 2'(NUM_KEYS - 1);

  state_t      state_q, state_d;
  logic [1:0]  stage_q, stage_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic        perr_q, perr_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [55:0] store_q [MAX_KEYS];
  logic [55:0] store_d [MAX_KEYS];
  logic [55:0] pc1_res [MAX_KEYS];
  logic        key_perr, accept, hs, blocked;
  logic [1:0]  stage_nxt, slot0, slot_nxt;
  logic        dir0, dir_cur, dir_nxt;

  assign accept    = key_valid & key_ready;
  assign hs        = subkey_valid & subkey_ready;
  assign blocked   = key_perr && (PARITY_BLOCK != 0);
  assign stage_nxt = stage_q + 2'd1;
  assign slot0     = stage_slot(2'd0, decrypt, NUM_KEYS);
  assign dir0      = stage_dir(2'd0, decrypt, NUM_KEYS);
  assign dir_cur   = stage_dir(stage_q, dec_q, NUM_KEYS);
  assign slot_nxt  = stage_slot(stage_nxt, dec_q, NUM_KEYS);
  assign dir_nxt   = stage_dir(stage_nxt, dec_q, NUM_KEYS);

  always_comb begin : pc1_parity
    key_perr = 1'b0;
    for (int s = 0; s < MAX_KEYS; s++) pc1_res[s] = '0;
    for (int s = 0; s < NUM_KEYS; s++) begin
      for (int i = 0; i < 56; i++) pc1_res[s][55-i] = key[64*s+64-PC1[i]];
      for (int b = 0; b < 8; b++) if (~^key[64*s+8*b +: 8]) key_perr = 1'b1;
    end
    if (PARITY_CHECK == 0) key_perr = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      perr_q  <= 1'b0;
      c_q     <= '0;
      d_q     <= '0;
      for (int s = 0; s < MAX_KEYS; s++) store_q[s] <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      perr_q  <= perr_d;
      c_q     <= c_d;
      d_q     <= d_d;
      store_q <= store_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !blocked) state_d = ST_RUN;
      ST_RUN:  if (hs && round_q == 4'd15 && stage_q == LAST_STAGE) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 0 is loaded at accept; later stages load on the round-15 handshake so there is no bubble.
  always_comb begin : datapath_next
    stage_d = stage_q;
    round_d = round_q;
    dec_d   = dec_q;
    perr_d  = perr_q;
    c_d     = c_q;
    d_d     = d_q;
    store_d = store_q;
    if (accept) begin
      store_d = pc1_res;
      dec_d   = decrypt;
      perr_d  = key_perr;
      if (!blocked) begin
        stage_d = 2'd0;
        round_d = 4'd0;
        c_d     = rot28(pc1_res[slot0][55:28], shift_amt(dir0, 4'd0), dir0);
        d_d     = rot28(pc1_res[slot0][27:0],  shift_amt(dir0, 4'd0), dir0);
      end
    end else if (hs) begin
      if (round_q != 4'd15) begin
        round_d = round_q + 4'd1;
        c_d     = rot28(c_q, shift_amt(dir_cur, round_q + 4'd1), dir_cur);
        d_d     = rot28(d_q, shift_amt(dir_cur, round_q + 4'd1), dir_cur);
      end else if (stage_q != LAST_STAGE) begin
        stage_d = stage_nxt;
        round_d = 4'd0;
        c_d     = rot28(store_q[slot_nxt][55:28], shift_amt(dir_nxt, 4'd0), dir_nxt);
        d_d     = rot28(store_q[slot_nxt][27:0],  shift_amt(dir_nxt, 4'd0), dir_nxt);
      end
    end
  end

  des_subkey_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

  always_comb begin : outputs
    key_ready    = (state_q == ST_IDLE) && !rst;
    busy         = (state_q == ST_RUN);
    subkey_valid = (state_q == ST_RUN);
    subkey_round = round_q;
    subkey_stage = stage_q;
    subkey_last  = subkey_valid && (round_q == 4'd15) && (stage_q == LAST_STAGE);
    parity_err   = perr_q;
  end

endmodule

// File: doc/des_key_schedule_seq.md
Name: des_key_schedule_seq

Overview:
Sequential DES / Triple-DES key schedule that emits one 48-bit round subkey per accepted handshake instead of all 16 at once.
It applies PC-1, the per-round C/D rotations and PC-2. It supports encrypt (left-rotate) and decrypt (right-rotate) order, and 1- or 3-key EDE operation.
It sits between the key-load interface and the round datapath, which pulls subkeys over a valid/ready handshake.

Parameters:
NUM_KEYS, 1, number of 64-bit keys: 1 = single DES, 3 = TDES EDE. Only 1 and 3 are legal; an elaboration-time assertion rejects other values.
PARITY_CHECK, 1, 1 = check odd parity on every key byte.
PARITY_BLOCK, 0, 1 = reject keys with bad parity (no subkeys produced); 0 = flag only.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
key_valid  in  1  key job offered
key_ready  out  1  block can accept a job
key  in  64*NUM_KEYS  slot s in key[64s+63:64s]; DES bit 1 = MSB of slot
decrypt  in  1  sampled with key: 0 = encrypt order, 1 = decrypt order
subkey_valid  out  1  subkey holds a valid round key
subkey_ready  in  1  consumer takes subkey
subkey  out  48  PC-2 output for the current round
subkey_round  out  4  round index 0..15 within the current stage
subkey_stage  out  2  stage 0..NUM_KEYS-1
subkey_last  out  1  final subkey of the job
parity_err  out  1  parity failure on the last accepted key job
busy  out  1  job in progress

Behaviour:
- Reset (async, any time, including mid-job): state = IDLE, all outputs 0, key_ready=0 while rst=1. Job is lost. key_ready=1 on the first clk after rst falls.
- FSM IDLE -> RUN -> IDLE. key_ready=1 only in IDLE. busy=1 in RUN.
- Accept: key_valid & key_ready. Latch PC-1(56 bits) of every slot into the key store, and latch decrypt.
- parity_err is updated on every accept: 1 if any byte of any slot has even parity, else 0. Held until the next accept. Forced 0 when PARITY_CHECK=0.
- If parity_err=1 and PARITY_BLOCK=1: stay in IDLE, no subkeys produced.
- Stage sequence:
  - NUM_KEYS=1: slot 0, direction = decrypt.
  - NUM_KEYS=3, encrypt: slots 0,1,2 with directions E,D,E.
  - NUM_KEYS=3, decrypt: slots 2,1,0 with directions D,E,D.
- Shift schedule per round r = 0..15:
  - E: left-rotate C and D by 1 for r in {0,1,8,15}, else by 2.
  - D: right-rotate by 0 for r=0, by 1 for r in {1,8,15}, else by 2.
- Stage load: C/D register = slot's PC-1 result with the round-0 shift already applied. This happens at accept for stage 0, and in the cycle stage s round 15 handshakes for stage s+1 (no bubble between stages).
- subkey = PC-2(C,D), driven combinationally from registers. subkey_valid rises the cycle after accept (latency 1).
- On subkey_valid & subkey_ready: round+1 with the next shift applied. If round=15, the stage advances.
- After the last subkey of the job handshakes: return to IDLE, subkey_valid=0 next cycle.
- subkey_valid stays high and subkey/round/stage stay stable while subkey_ready=0.
- subkey_last = subkey_valid & round=15 & stage=NUM_KEYS-1.
- key_valid during RUN is ignored (key_ready=0). Minimum job spacing: 16*NUM_KEYS+1 cycles.
- After a full rotation sequence C/D returns to its PC-1 value. Required as a design invariant; the bench checks it.

Decomposition:
- Package des_pkg holds: PC1 and PC2 tables (1-based, DES bit order), E/D shift-amount tables indexed by round, FSM state encoding, and a function giving slot/direction per stage and mode.
- Sub-module des_subkey_pc2: purely combinational 56->48 PC-2 selection.
- PC-1 is applied inline per slot at accept.

Test Plan:
- NUM_KEYS=1, key=0x133457799BBCDFF1, decrypt=0, subkey_ready=1 -> subkey 0x1B02EFFC7072 one cycle after accept; 16 consecutive subkeys; last = 0xCB3D8B0E17F5 with subkey_last=1; parity_err=0.
- Same key, decrypt=1 -> first subkey 0xCB3D8B0E17F5, last 0x1B02EFFC7072; sequence exactly the encrypt order reversed.
- key=0x133457799BBCDFF0 -> parity_err=1. PARITY_BLOCK=1: no subkey_valid and key_ready stays 1. PARITY_BLOCK=0: normal 16 subkeys.
- Random subkey_ready stalls -> subkey/round/stage stable while stalled; no subkey skipped or duplicated versus the reference model.
- NUM_KEYS=3, K1=K3=0x133457799BBCDFF1, K2 random, encrypt -> 48 subkeys; stage 1 equals K2's decrypt order; no gap between round 15 and the next stage's round 0; subkey_last only on subkey 48.
- rst asserted mid-job at round 7 -> outputs 0 asynchronously; after release, a new key produces a correct full sequence with no residue from the aborted job.
